// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter constants and PC slicing.
// Widths are passed in, so one package serves every parameterisation.
package bp_pkg;

  // Largest value of a cnt_w-bit saturating counter.
  function automatic logic [31:0] cnt_max(input int cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Weakly-taken value: MSB set, all lower bits clear.
  function automatic logic [31:0] cnt_weak_t(input int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // BTB index: word-aligned PC bits just above the byte offset.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // BTB tag: every PC bit above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one saturating taken/not-taken counter.
// Priority: force_max, then load_weak, then inc, then dec.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             inc,
  input  logic             dec,
  input  logic             force_max,
  input  logic             load_weak,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(cnt_weak_t(CNT_W));

  // Select the counter's next value, holding at both rails.
  always_comb begin
    cnt_out = cnt_in;
    if (force_max) begin
      cnt_out = CNT_MAX;
    end else if (load_weak) begin
      cnt_out = CNT_WEAK_T;
    end else if (inc && (cnt_in != CNT_MAX)) begin
      cnt_out = cnt_in + 1'b1;
    end else if (dec && (cnt_in != '0)) begin
      cnt_out = cnt_in - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters. Lookup is combinational
// from the IF-stage PC; training comes from the ID-stage resolution and lands
// on the next rising edge. Also keeps a saturating mispredict count.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_is_jump,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              invalidate,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  counter;
  } entry_t;

  // Flops rather than RAM: the whole table must clear asynchronously and
  // all valid bits must drop in a single cycle on invalidate.
  entry_t r_table [ENTRIES];
  logic [STAT_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  entry_t           w_lk_entry, w_up_entry;
  logic             w_lk_hit, w_up_hit;
  logic             w_write, w_tgt_wr;
  logic [CNT_W-1:0] w_cnt_in, w_cnt_next;

  // Lookup side: no bypass from a same-cycle update by design.
  assign w_lk_idx   = IDX_W'(pc_index(64'(pc_in), IDX_W));
  assign w_lk_tag   = TAG_W'(pc_tag(64'(pc_in), IDX_W));
  assign w_lk_entry = r_table[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

  assign pred_hit     = w_lk_hit;
  assign pred_taken   = w_lk_hit && w_lk_entry.counter[CNT_W-1];
  assign pred_next_pc = pred_taken ? w_lk_entry.target : (pc_in + ADDR_W'(4));

  // Update side.
  assign w_up_idx   = IDX_W'(pc_index(64'(upd_pc), IDX_W));
  assign w_up_tag   = TAG_W'(pc_tag(64'(upd_pc), IDX_W));
  assign w_up_entry = r_table[w_up_idx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

  // A not-taken miss leaves the table alone; everything else writes the entry.
  assign w_write  = upd_valid && (w_up_hit || upd_taken);
  assign w_tgt_wr = upd_taken || upd_is_jump;
  assign w_cnt_in = w_up_hit ? w_up_entry.counter : '0;

  bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cnt_in    (w_cnt_in),
    .inc       (w_up_hit && !upd_is_jump && upd_taken),
    .dec       (w_up_hit && !upd_is_jump && !upd_taken),
    .force_max (upd_is_jump),
    .load_weak (!w_up_hit && !upd_is_jump),
    .cnt_out   (w_cnt_next)
  );

  // Table state: reset clears everything, invalidate beats a same-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= '0;
    end else if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i].valid <= 1'b0;
    end else if (w_write) begin
      r_table[w_up_idx].valid   <= 1'b1;
      r_table[w_up_idx].tag     <= w_up_tag;
      r_table[w_up_idx].counter <= w_cnt_next;
      if (w_tgt_wr) r_table[w_up_idx].target <= upd_target;
    end
  end

  // Mispredict statistic, saturating at all-ones, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mis_cnt <= '0;
    end else if (upd_valid && upd_mispredict && (r_mis_cnt != '1)) begin
      r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default table, 2-bit mispredict count).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid, upd_taken, upd_is_jump, upd_mispredict, invalidate;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  mispredict_count;
  logic [33:0] obs;

  int checks = 0;
  int errors = 0;

  // Clock.
  always #5 clk = ~clk;

  assign obs = {pred_hit, pred_taken, pred_next_pc};

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_in            (pc_in),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_is_jump      (upd_is_jump),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .invalidate       (invalidate),
    .mispredict_count (mispredict_count)
  );

  // Driver: present one update for exactly one rising edge (call at a negedge).
  task automatic upd(input logic [31:0] pc, input logic taken, input logic jump,
                     input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_is_jump = jump;
    upd_target = tgt; upd_mispredict = mis;
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pc_in = pc;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; pc_in = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_is_jump = 0; upd_target = 0; upd_mispredict = 0; invalidate = 0;
    #1;
    checks++;
    if (obs !== {2'b00, 32'h44}) begin
      errors++; $display("FAIL reset_lookup got %h exp %h", obs, {2'b00, 32'h44});
    end
    checks++;
    if (mispredict_count !== 2'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", mispredict_count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_train;
    upd(32'h40, 1, 0, 32'h80, 0);
    lookup(32'h40);
    checks++;
    if (obs !== {2'b11, 32'h80}) begin
      errors++; $display("FAIL train_alloc got %h exp %h", obs, {2'b11, 32'h80});
    end
    @(negedge clk); upd(32'h40, 0, 0, 32'h0, 0);
    lookup(32'h40);
    checks++;
    if (obs !== {2'b10, 32'h44}) begin
      errors++; $display("FAIL train_weak_nt got %h exp %h", obs, {2'b10, 32'h44});
    end
    @(negedge clk); upd(32'h40, 0, 0, 32'h0, 0);
    upd(32'h40, 1, 0, 32'h80, 0);
    lookup(32'h40);
    checks++;
    if (obs !== {2'b10, 32'h44}) begin
      errors++; $display("FAIL train_floor got %h exp %h", obs, {2'b10, 32'h44});
    end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    for (int i = 0; i < 4; i++) upd(32'h104, 1, 0, 32'h200, 0);
    upd(32'h104, 0, 0, 32'h0, 0);
    lookup(32'h104);
    checks++;
    if (obs !== {2'b11, 32'h200}) begin
      errors++; $display("FAIL sat_top got %h exp %h", obs, {2'b11, 32'h200});
    end
    @(negedge clk); upd(32'h104, 0, 0, 32'h0, 0);
    lookup(32'h104);
    checks++;
    if (obs !== {2'b10, 32'h108}) begin
      errors++; $display("FAIL sat_down got %h exp %h", obs, {2'b10, 32'h108});
    end
  endtask

  task automatic test_alias_jump;
    @(negedge clk); upd(32'h80, 1, 0, 32'h300, 0);
    lookup(32'h40);
    checks++;
    if (obs !== {2'b00, 32'h44}) begin
      errors++; $display("FAIL alias_old got %h exp %h", obs, {2'b00, 32'h44});
    end
    @(negedge clk); upd(32'hC0, 0, 0, 32'h999, 0);
    lookup(32'hC0);
    checks++;
    if (obs !== {2'b00, 32'hC4}) begin
      errors++; $display("FAIL alias_nt_miss got %h exp %h", obs, {2'b00, 32'hC4});
    end
    lookup(32'h80);
    checks++;
    if (obs !== {2'b11, 32'h300}) begin
      errors++; $display("FAIL alias_new got %h exp %h", obs, {2'b11, 32'h300});
    end
    @(negedge clk);
    upd(32'h208, 1, 1, 32'h10, 0);
    upd(32'h208, 0, 0, 32'h0, 0);
    lookup(32'h208);
    checks++;
    if (obs !== {2'b11, 32'h10}) begin
      errors++; $display("FAIL jump_miss got %h exp %h", obs, {2'b11, 32'h10});
    end
    @(negedge clk);
    upd(32'h104, 1, 1, 32'h400, 0);
    upd(32'h104, 0, 0, 32'h0, 0);
    lookup(32'h104);
    checks++;
    if (obs !== {2'b11, 32'h400}) begin
      errors++; $display("FAIL jump_hit got %h exp %h", obs, {2'b11, 32'h400});
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    pc_in = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_is_jump = 1'b0;
    upd_target = 32'h500; upd_mispredict = 1'b0;
    #1;
    checks++;
    if (obs !== {2'b00, 32'h44}) begin
      errors++; $display("FAIL same_cycle_old got %h exp %h", obs, {2'b00, 32'h44});
    end
    @(negedge clk);
    upd_valid = 1'b0;
    lookup(32'h40);
    checks++;
    if (obs !== {2'b11, 32'h500}) begin
      errors++; $display("FAIL same_cycle_new got %h exp %h", obs, {2'b11, 32'h500});
    end
    @(negedge clk);
    invalidate = 1'b1;
    upd(32'h208, 1, 0, 32'h600, 0);
    invalidate = 1'b0;
    lookup(32'h40);
    checks++;
    if (obs !== {2'b00, 32'h44}) begin
      errors++; $display("FAIL inval_a got %h exp %h", obs, {2'b00, 32'h44});
    end
    lookup(32'h208);
    checks++;
    if (obs !== {2'b00, 32'h20C}) begin
      errors++; $display("FAIL inval_b got %h exp %h", obs, {2'b00, 32'h20C});
    end
    lookup(32'h104);
    checks++;
    if (obs !== {2'b00, 32'h108}) begin
      errors++; $display("FAIL inval_c got %h exp %h", obs, {2'b00, 32'h108});
    end
  endtask

  task automatic test_wrap;
    lookup(32'hFFFF_FFFC);
    checks++;
    if (obs !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL wrap_miss got %h exp %h", obs, {2'b00, 32'h0});
    end
    @(negedge clk); upd(32'hFFFF_FFFC, 1, 0, 32'h1234, 0);
    lookup(32'hFFFF_FFFC);
    checks++;
    if (obs !== {2'b11, 32'h1234}) begin
      errors++; $display("FAIL wrap_hit got %h exp %h", obs, {2'b11, 32'h1234});
    end
  endtask

  task automatic test_mispredict;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    upd_mispredict = 1'b1;
    @(negedge clk);
    upd_mispredict = 1'b0;
    checks++;
    if (mispredict_count !== 2'd0) begin
      errors++; $display("FAIL mis_unqualified got %0d exp 0", mispredict_count);
    end
    for (int i = 0; i < 5; i++) begin
      upd(32'hC0, 0, 0, 32'h0, 1);
      checks++;
      if (mispredict_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL mis_count_%0d got %0d exp %0d", i, mispredict_count, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); upd(32'h40, 1, 0, 32'h80, 0);
    lookup(32'h40);
    checks++;
    if (obs !== {2'b11, 32'h80}) begin
      errors++; $display("FAIL pre_reset got %h exp %h", obs, {2'b11, 32'h80});
    end
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_is_jump = 1'b0;
    upd_target = 32'h700; upd_mispredict = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== {2'b00, 32'h44}) begin
      errors++; $display("FAIL mid_reset_lookup got %h exp %h", obs, {2'b00, 32'h44});
    end
    checks++;
    if (mispredict_count !== 2'd0) begin
      errors++; $display("FAIL mid_reset_count got %0d exp 0", mispredict_count);
    end
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    rst = 1'b1;
    lookup(32'h104);
    checks++;
    if (obs !== {2'b00, 32'h108}) begin
      errors++; $display("FAIL mid_reset_drop got %h exp %h", obs, {2'b00, 32'h108});
    end
  endtask

  initial begin
    test_reset;
    test_train;
    test_saturate;
    test_alias_jump;
    test_same_cycle;
    test_wrap;
    test_mispredict;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
